fetch_if: RTL and testbench

// - Instruction fetch stage, directly upstream of the decoder. Owns the fetch PC.
// - Issues 32-bit word requests to instruction memory and buffers in-order responses in a prefetch FIFO.
// - Presents {instr, pc} pairs to decode over a valid/ready handshake.
// - Accepts a control-flow redirect from execute, which flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_if_if.sv | 23 ++
 rtl/fetch_if.sv | 81 ++++++++
 tb/tb_fetch_if.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_if_if.sv
// fetch_if_if: redirect, instruction-memory and decode handshake signals of the fetch stage
interface fetch_if_if;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_instr;
  logic [63:0] o_if_pc;
  logic        i_id_ready;
  logic        o_if_misaligned;
  modport master (
    input  i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_id_ready,
    output o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_if_misaligned
  );
  modport slave (
    output i_redirect, i_redirect_pc, i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_id_ready,
    input  o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_if_misaligned
  );
endinterface

// File: rtl/fetch_if.sv
// fetch_if: fetch PC, imem requests, prefetch FIFO toward decode, redirect flush; CH0RE_IF_MISALIGN_CHECK_EN enables the misaligned-redirect fault
module fetch_if #(
  parameter logic [63:0] BOOT_ADDR  = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic        i_clk,
  input logic        i_rst_n,
  fetch_if_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);
  logic [63:0]   fetch_pc, resp_pc, target;
  logic [CW-1:0] count, in_flight, discard;
  logic [AW-1:0] wptr, rptr;
  logic [31:0]   instr_q [FIFO_DEPTH];
  logic [63:0]   pc_q [FIFO_DEPTH];
  logic [CW:0]   occupancy;
  logic          mis, mis_next, req, valid, fire, push, pop, rv;
`ifdef CH0RE_IF_MISALIGN_CHECK_EN
  assign target              = bus.i_redirect_pc;
  assign mis_next            = |bus.i_redirect_pc[1:0];
  assign bus.o_if_misaligned = mis;
`else
  assign target              = {bus.i_redirect_pc[63:2], 2'b00};
  assign mis_next            = 1'b0;
  assign bus.o_if_misaligned = 1'b0;
`endif
  // Requests reserve a FIFO slot up front, so in-flight plus buffered never exceeds the depth
  always_comb begin
    rv        = bus.i_imem_rvalid;
    occupancy = {1'b0, in_flight} + {1'b0, count};
    req       = i_rst_n & (occupancy < DEPTH_W) & ~bus.i_redirect & ~mis;
    valid     = i_rst_n & (count != '0);
    fire      = req & bus.i_imem_gnt;
    push      = i_rst_n & rv & (discard == '0) & ~bus.i_redirect;
    pop       = valid & bus.i_id_ready & ~bus.i_redirect;
  end
  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = fetch_pc;
  assign bus.o_if_valid  = valid;
  assign bus.o_if_instr  = valid ? instr_q[rptr] : 32'd0;
  assign bus.o_if_pc     = valid ? pc_q[rptr] : 64'd0;
  // PCs, occupancy counters and fault flag; a redirect turns every outstanding response into a discard
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_pc  <= BOOT_ADDR;
      resp_pc   <= BOOT_ADDR;
      count     <= '0;
      in_flight <= '0;
      discard   <= '0;
      wptr      <= '0;
      rptr      <= '0;
      mis       <= 1'b0;
    end else if (bus.i_redirect) begin
      fetch_pc  <= target;
      resp_pc   <= target;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      in_flight <= in_flight - CW'(rv);
      discard   <= in_flight - CW'(rv);
      mis       <= mis_next;
    end else begin
      fetch_pc  <= fire ? fetch_pc + 64'd4 : fetch_pc;
      resp_pc   <= push ? resp_pc + 64'd4 : resp_pc;
      count     <= count + CW'(push) - CW'(pop);
      in_flight <= in_flight + CW'(fire) - CW'(rv);
      discard   <= (rv && discard != '0) ? discard - CW'(1) : discard;
      wptr      <= push ? wptr + AW'(1) : wptr;
      rptr      <= pop ? rptr + AW'(1) : rptr;
    end
  end
  // FIFO storage; each accepted word is tagged with the PC it was fetched from
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_q[wptr] <= bus.i_imem_rdata;
      pc_q[wptr]    <= resp_pc;
    end
  end
endmodule

// File: tb/tb_fetch_if.sv
// tb_fetch_if: randomized self-checking bench for fetch_if against a request-queue / instruction-stream model
module tb_fetch_if;
  localparam logic [63:0] BOOT  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4;
  typedef struct {
    logic [63:0] addr;
    bit          stale;
  } req_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  req_t        outq[$];
  int          nbuf = 0;
  logic [63:0] m_fetch = BOOT;
  logic [63:0] m_dpc = BOOT;
  bit          m_mis = 1'b0;
  fetch_if_if bus();
  fetch_if #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] word(logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h1357_2468;
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(bit rst, bit redir, logic [63:0] rpc, bit gnt, bit rvq, bit rdy);
    bit   rv, rd, exp_req, exp_valid, fire, pop;
    req_t e;
    @(negedge clk);
    rd                = redir && !rst;
    rv                = rvq && !rst && outq.size() > 0;
    rst_n             = !rst;
    bus.i_redirect    = rd;
    bus.i_redirect_pc = rpc;
    bus.i_imem_gnt    = gnt;
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = rv ? word(outq[0].addr) : 32'($urandom);
    bus.i_id_ready    = rdy;
    #1;
    exp_req   = !rst && !rd && !m_mis && (outq.size() + nbuf < DEPTH);
    exp_valid = !rst && nbuf > 0;
    check("req", 64'(bus.o_imem_req), 64'(exp_req));
    if (exp_req) check("addr", bus.o_imem_addr, m_fetch);
    check("valid", 64'(bus.o_if_valid), 64'(exp_valid));
    check("pc", bus.o_if_pc, exp_valid ? m_dpc : 64'd0);
    check("instr", 64'(bus.o_if_instr), exp_valid ? 64'(word(m_dpc)) : 64'd0);
    if (!rst) check("misaligned", 64'(bus.o_if_misaligned), 64'(m_mis));
    fire = exp_req && gnt;
    pop  = exp_valid && rdy && !rd;
    if (rst) begin
      outq.delete();
      nbuf    = 0;
      m_fetch = BOOT;
      m_dpc   = BOOT;
      m_mis   = 1'b0;
    end else begin
      if (rv) begin
        e = outq.pop_front();
        if (!e.stale && !rd) nbuf++;
      end
      if (rd) begin
        foreach (outq[i]) outq[i].stale = 1'b1;
        nbuf = 0;
`ifdef CH0RE_IF_MISALIGN_CHECK_EN
        m_fetch = rpc;
        m_mis   = rpc[1:0] != 2'b00;
`else
        m_fetch = {rpc[63:2], 2'b00};
        m_mis   = 1'b0;
`endif
        m_dpc = m_fetch;
      end else begin
        if (pop) begin
          nbuf--;
          m_dpc += 64'd4;
        end
        if (fire) begin
          outq.push_back('{m_fetch, 1'b0});
          m_fetch += 64'd4;
        end
      end
    end
  endtask
  task automatic do_reset();
    repeat (2) step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    bit          r_rst, r_rd, r_gnt, r_rv, r_rdy;
    logic [63:0] t;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 64'd0;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'd0;
    bus.i_id_ready    = 1'b0;
    do_reset();
    repeat (12) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    do_reset();
    repeat (10) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    do_reset();
    repeat (3) step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    do_reset();
    repeat (3) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 64'h1000, 1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    do_reset();
    repeat (2) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 64'h2000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 64'h3000, 1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 64'h1002, 1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 64'h1004, 1'b1, 1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      r_rst = $urandom_range(0, 499) == 0;
      r_rd  = $urandom_range(0, 29) == 0;
      r_gnt = $urandom_range(0, 99) < 70;
      r_rv  = $urandom_range(0, 99) < 60;
      r_rdy = $urandom_range(0, 99) < 65;
      t     = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      step(r_rst, r_rd, t, r_gnt, r_rv, r_rdy);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
